// File: rtl/controlador_semaforos.sv
// Two-way crossing traffic-light sequencer with per-second countdown and request-driven green shortening.
// Lamps and Numero are registered; a 1-cycle request pulse only influences the next prescaler tick.
module controlador_semaforos #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int T_VERDE     = 9,
    parameter int T_AMARILLO  = 3,
    parameter int T_ROJO      = 1,
    parameter int T_MIN_VERDE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    output logic       VA,
    output logic       AA,
    output logic       RA,
    output logic       VB,
    output logic       AB,
    output logic       RB,
    output logic [3:0] Numero
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [3:0] SHORT_LIMIT = 4'(T_VERDE - T_MIN_VERDE + 1);

    typedef enum logic [2:0] {
        A_VERDE,
        A_AMARILLO,
        ROJO_1,
        B_VERDE,
        B_AMARILLO,
        ROJO_2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            leave;
    logic [3:0]      numero_nxt;
    logic            pend_a, pend_b, pend_a_nxt, pend_b_nxt;
    logic [5:0]      lamps, lamps_nxt;

    always_comb begin
        tick       = (presc == PW'(CLK_HZ - 1));
        leave      = 1'b0;
        state_nxt  = state;
        numero_nxt = Numero;
        lamps_nxt  = 6'b100001;

        // A pending request cuts the current green once the minimum green has elapsed.
        if (tick) begin
            if (Numero == 4'd1)
                leave = 1'b1;
            if (state == A_VERDE && pend_b && Numero <= SHORT_LIMIT)
                leave = 1'b1;
            if (state == B_VERDE && pend_a && Numero <= SHORT_LIMIT)
                leave = 1'b1;
        end

        if (leave) begin
            case (state)
                A_VERDE:    state_nxt = A_AMARILLO;
                A_AMARILLO: state_nxt = ROJO_1;
                ROJO_1:     state_nxt = B_VERDE;
                B_VERDE:    state_nxt = B_AMARILLO;
                B_AMARILLO: state_nxt = ROJO_2;
                ROJO_2:     state_nxt = A_VERDE;
                default:    state_nxt = A_VERDE;
            endcase
        end

        case (state_nxt)
            A_VERDE:    lamps_nxt = 6'b100001;
            A_AMARILLO: lamps_nxt = 6'b010001;
            ROJO_1:     lamps_nxt = 6'b001001;
            B_VERDE:    lamps_nxt = 6'b001100;
            B_AMARILLO: lamps_nxt = 6'b001010;
            ROJO_2:     lamps_nxt = 6'b001001;
            default:    lamps_nxt = 6'b100001;
        endcase

        if (leave) begin
            case (state_nxt)
                A_VERDE, B_VERDE:       numero_nxt = 4'(T_VERDE);
                A_AMARILLO, B_AMARILLO: numero_nxt = 4'(T_AMARILLO);
                default:                numero_nxt = 4'(T_ROJO);
            endcase
        end else if (tick) begin
            numero_nxt = Numero - 4'd1;
        end

        pend_a_nxt = pend_a;
        if (req_a && state != A_VERDE)
            pend_a_nxt = 1'b1;
        if (leave && state_nxt == A_VERDE)
            pend_a_nxt = 1'b0;

        pend_b_nxt = pend_b;
        if (req_b && state != B_VERDE)
            pend_b_nxt = 1'b1;
        if (leave && state_nxt == B_VERDE)
            pend_b_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= A_VERDE;
            Numero <= 4'(T_VERDE);
            presc  <= '0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            lamps  <= 6'b100001;
        end else begin
            state  <= state_nxt;
            Numero <= numero_nxt;
            presc  <= tick ? '0 : presc + PW'(1);
            pend_a <= pend_a_nxt;
            pend_b <= pend_b_nxt;
            lamps  <= lamps_nxt;
        end
    end

    assign {VA, AA, RA, VB, AB, RB} = lamps;

endmodule

// File: tb/tb_controlador_semaforos.sv
// Directed vector bench for controlador_semaforos with a 4-cycle second, plus a per-cycle lamp invariant monitor.
module tb_controlador_semaforos;

    localparam logic [5:0] L_AV = 6'b100001;
    localparam logic [5:0] L_AA = 6'b010001;
    localparam logic [5:0] L_RR = 6'b001001;
    localparam logic [5:0] L_BV = 6'b001100;
    localparam logic [5:0] L_BA = 6'b001010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       VA, AA, RA, VB, AB, RB;
    logic [3:0] Numero;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    typedef struct {
        logic       rst;
        logic       ra;
        logic       rb;
        int         n;
        logic [5:0] lamps;
        logic [3:0] num;
    } vec_t;

    vec_t tv[$];

    controlador_semaforos #(
        .CLK_HZ(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_a(req_a),
        .req_b(req_b),
        .VA(VA),
        .AA(AA),
        .RA(RA),
        .VB(VB),
        .AB(AB),
        .RB(RB),
        .Numero(Numero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] exp_l, input logic [3:0] exp_n);
        logic [5:0] act_l;
        act_l = {VA, AA, RA, VB, AB, RB};
        total++;
        if (act_l !== exp_l || Numero !== exp_n) begin
            bad++;
            $display("FAIL %s lamps=%b num=%0d expected lamps=%b num=%0d", name, act_l, Numero, exp_l, exp_n);
        end
    endtask

    // Safety invariants checked on every falling edge once the design is out of reset.
    always @(negedge clk) begin
        if (started) begin
            total++;
            if (!$onehot({VA, AA, RA}) || !$onehot({VB, AB, RB})) begin
                bad++;
                $display("FAIL onehot lamps=%b expected one-hot per direction", {VA, AA, RA, VB, AB, RB});
            end
            total++;
            if (VA && VB) begin
                bad++;
                $display("FAIL both_green VA=%b VB=%b expected not both", VA, VB);
            end
            total++;
            if (Numero < 4'd1 || Numero > 4'd9) begin
                bad++;
                $display("FAIL numero_range num=%0d expected 1..9", Numero);
            end
        end
    end

    initial begin
        // Idle run from reset.
        tv.push_back('{1'b1, 1'b0, 1'b0, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 35, L_AV, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_AA, 4'd3});
        tv.push_back('{1'b0, 1'b0, 1'b0, 11, L_AA, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_RR, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 3,  L_RR, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_BV, 4'd9});
        // req_b right after reset: green cut at Numero 7.
        tv.push_back('{1'b1, 1'b0, 1'b0, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 10, L_AV, 4'd7});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_AA, 4'd3});
        // req_b at Numero 2: leave one second early, then req_a in B green at 9.
        tv.push_back('{1'b1, 1'b0, 1'b0, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 28, L_AV, 4'd2});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1,  L_AV, 4'd2});
        tv.push_back('{1'b0, 1'b0, 1'b0, 2,  L_AV, 4'd2});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_AA, 4'd3});
        tv.push_back('{1'b0, 1'b0, 1'b0, 15, L_RR, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_BV, 4'd9});
        tv.push_back('{1'b0, 1'b1, 1'b0, 1,  L_BV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 10, L_BV, 4'd7});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_BA, 4'd3});
        // Reset in B yellow with pend_a set: pending request lost, both greens full.
        tv.push_back('{1'b1, 1'b0, 1'b0, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 35, L_AV, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_AA, 4'd3});
        tv.push_back('{1'b0, 1'b0, 1'b0, 16, L_BV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 35, L_BV, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_BA, 4'd3});
        // req_a in A green and req_b in B green are ignored.
        tv.push_back('{1'b1, 1'b0, 1'b0, 1,  L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b1, 1'b0, 5,  L_AV, 4'd8});
        tv.push_back('{1'b0, 1'b0, 1'b0, 30, L_AV, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_AA, 4'd3});
        tv.push_back('{1'b0, 1'b0, 1'b0, 16, L_BV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 12, L_BV, 4'd6});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1,  L_BV, 4'd6});
        tv.push_back('{1'b0, 1'b0, 1'b0, 22, L_BV, 4'd1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1,  L_BA, 4'd3});
        tv.push_back('{1'b0, 1'b0, 1'b0, 16, L_AV, 4'd9});
        tv.push_back('{1'b0, 1'b0, 1'b0, 12, L_AV, 4'd6});

        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst;
            req_a = tv[i].ra;
            req_b = tv[i].rb;
            @(posedge clk);
            #1;
            reset = 1'b0;
            req_a = 1'b0;
            req_b = 1'b0;
            if (tv[i].n > 1) begin
                repeat (tv[i].n - 1) @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d", i), tv[i].lamps, tv[i].num);
            started = 1'b1;
        end

        // Request landing on a tick edge is latched but only acts on the following tick.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("tick_req_reset", L_AV, 4'd9);
        repeat (11) @(posedge clk);
        #1;
        check("tick_req_pre", L_AV, 4'd7);
        req_b = 1'b1;
        @(posedge clk);
        #1;
        req_b = 1'b0;
        check("tick_req_same_edge", L_AV, 4'd6);
        repeat (3) @(posedge clk);
        #1;
        check("tick_req_hold", L_AV, 4'd6);
        @(posedge clk);
        #1;
        check("tick_req_leave", L_AA, 4'd3);

        // Short soak at the end so the invariant monitor sees a few more cycles.
        repeat (3) @(posedge clk);
        #1;
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
